// File: rtl/paddle_input.sv
// Paddle timer front end for the Breakout core: turns absolute/mouse/joystick position into a 555-style PAD_OUT pulse.
// Optional build macro PADDLE_COCKTAIL_MIRROR_EN mirrors the position for player 2 on a cocktail cabinet.
module paddle_input #(
   parameter int unsigned POS_MIN     = 16,
   parameter int unsigned POS_MAX     = 208,
   parameter int unsigned POS_CENTER  = 112,
   parameter int unsigned LINE_OFFSET = 8,
   parameter int unsigned JOY_STEP    = 4
) (
   input  logic       CLK_SRC,
   input  logic       RESET_N,
   input  logic       HSYNC,
   input  logic       VSYNC,
   input  logic       PAD_EN_N,
   input  logic       MODE,
   input  logic [7:0] PADDLE_POS,
   input  logic       MOUSE_STB,
   input  logic [8:0] MOUSE_DX,
   input  logic       JOY_L,
   input  logic       JOY_R,
   input  logic       PLAYER2,
   input  logic       COCKTAIL,
   output logic       PAD_OUT,
   output logic [7:0] POS
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_TIMING = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;

   logic              r_hs, r_hs_d, r_vs, r_vs_d, r_en, r_en_d, r_ms, r_ms_d;
   logic        [7:0] r_pos;
   logic signed [9:0] r_acc;
   logic        [8:0] r_cnt;
   logic        [8:0] r_target;
   logic        [1:0] r_state;
   logic              r_pad;
   logic        [7:0] r_pos_out;

   logic               w_hs_rise, w_vs_rise, w_en_fall, w_ms_edge;
   logic signed [10:0] w_acc_sum;
   logic signed [9:0]  w_acc_sat;
   logic signed [9:0]  w_dx_ext;
   logic signed [10:0] w_joy;
   logic signed [10:0] w_rel_new;
   logic        [7:0]  w_pos_next;
   logic        [7:0]  w_pos_eff;
   logic        [8:0]  w_cnt_next;

   function automatic logic [7:0] clamp_pos(input logic signed [10:0] v);
      logic [7:0] res;
      if (v < $signed(11'(POS_MIN))) begin
         res = 8'(POS_MIN);
      end else if (v > $signed(11'(POS_MAX))) begin
         res = 8'(POS_MAX);
      end else begin
         res = v[7:0];
      end
      return res;
   endfunction

   // Input registration with one previous sample kept for edge detection
   always_ff @(posedge CLK_SRC) begin
      if (!RESET_N) begin
         r_hs   <= 1'b1;
         r_hs_d <= 1'b1;
         r_vs   <= 1'b1;
         r_vs_d <= 1'b1;
         r_en   <= 1'b1;
         r_en_d <= 1'b1;
         r_ms   <= 1'b0;
         r_ms_d <= 1'b0;
      end else begin
         r_hs   <= HSYNC;
         r_hs_d <= r_hs;
         r_vs   <= VSYNC;
         r_vs_d <= r_vs;
         r_en   <= PAD_EN_N;
         r_en_d <= r_en;
         r_ms   <= MOUSE_STB;
         r_ms_d <= r_ms;
      end
   end

   assign w_hs_rise  = r_hs & ~r_hs_d;
   assign w_vs_rise  = r_vs & ~r_vs_d;
   assign w_en_fall  = ~r_en & r_en_d;
   assign w_ms_edge  = r_ms ^ r_ms_d;
   assign w_dx_ext   = {MOUSE_DX[8], MOUSE_DX};
   assign w_acc_sum  = {r_acc[9], r_acc} + {w_dx_ext[9], w_dx_ext};
   assign w_rel_new  = $signed({3'b000, r_pos}) + {r_acc[9], r_acc} + w_joy;
   assign w_cnt_next = r_cnt + 9'd1;

   // Accumulator saturation and joystick step selection
   always_comb begin
      w_acc_sat = w_acc_sum[9:0];
      if (w_acc_sum > 11'sd255) begin
         w_acc_sat = 10'sd255;
      end else if (w_acc_sum < -11'sd256) begin
         w_acc_sat = -10'sd256;
      end else begin
         w_acc_sat = w_acc_sum[9:0];
      end
      w_joy = 11'sd0;
      if (JOY_R && !JOY_L) begin
         w_joy = $signed(11'(JOY_STEP));
      end else if (JOY_L && !JOY_R) begin
         w_joy = -$signed(11'(JOY_STEP));
      end else begin
         w_joy = 11'sd0;
      end
   end

   // Frame position source: absolute paddle or relative mouse+joystick
   always_comb begin
      w_pos_next = r_pos;
      if (MODE) begin
         w_pos_next = clamp_pos($signed({3'b000, PADDLE_POS}));
      end else begin
         w_pos_next = clamp_pos(w_rel_new);
      end
   end

`ifdef PADDLE_COCKTAIL_MIRROR_EN
   assign w_pos_eff = (PLAYER2 && COCKTAIL) ? (8'(POS_MIN + POS_MAX) - r_pos) : r_pos;
`else
   logic w_unused_mirror;
   assign w_unused_mirror = PLAYER2 ^ COCKTAIL;
   assign w_pos_eff       = r_pos;
`endif

   // Mouse accumulation; a packet landing on the frame edge seeds the next frame
   always_ff @(posedge CLK_SRC) begin
      if (!RESET_N) begin
         r_acc <= 10'sd0;
         r_pos <= 8'(POS_CENTER);
      end else if (w_vs_rise) begin
         r_acc <= w_ms_edge ? w_dx_ext : 10'sd0;
         r_pos <= w_pos_next;
      end else if (w_ms_edge) begin
         r_acc <= w_acc_sat;
         r_pos <= r_pos;
      end else begin
         r_acc <= r_acc;
         r_pos <= r_pos;
      end
   end

   // Pulse timer; target is latched at the trigger so later position changes cannot stretch it
   always_ff @(posedge CLK_SRC) begin
      if (!RESET_N) begin
         r_state   <= ST_IDLE;
         r_pad     <= 1'b0;
         r_cnt     <= 9'd0;
         r_target  <= 9'd0;
         r_pos_out <= 8'(POS_CENTER);
      end else begin
         r_pos_out <= w_pos_eff;
         case (r_state)
            ST_IDLE: begin
               r_pad <= 1'b0;
               if (w_en_fall) begin
                  r_target <= 9'(LINE_OFFSET) + {1'b0, w_pos_eff};
                  r_cnt    <= 9'd0;
                  r_pad    <= 1'b1;
                  r_state  <= ST_TIMING;
               end
            end
            ST_TIMING: begin
               r_pad <= 1'b1;
               if (w_hs_rise) begin
                  r_cnt <= w_cnt_next;
                  if (w_cnt_next == r_target) begin
                     r_pad   <= 1'b0;
                     r_state <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               r_pad <= 1'b0;
               if (r_en) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_pad   <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign PAD_OUT = r_pad;
   assign POS     = r_pos_out;

endmodule

// File: tb/tb_paddle_input.sv
// Self-checking bench for paddle_input: integer reference model of position, accumulator and pulse length.
module tb_paddle_input;

   logic       CLK_SRC = 1'b0;
   logic       RESET_N = 1'b0;
   logic       HSYNC = 1'b0, VSYNC = 1'b0, PAD_EN_N = 1'b1, MODE = 1'b0;
   logic [7:0] PADDLE_POS = 8'd0;
   logic       MOUSE_STB = 1'b0;
   logic [8:0] MOUSE_DX = 9'd0;
   logic       JOY_L = 1'b0, JOY_R = 1'b0, PLAYER2 = 1'b0, COCKTAIL = 1'b0;
   logic       PAD_OUT;
   logic [7:0] POS;

   int n_checks = 0;
   int n_pass   = 0;
   int m_pos    = 112;
   int m_acc    = 0;

   always #5 CLK_SRC = ~CLK_SRC;

   paddle_input dut (
      .CLK_SRC(CLK_SRC), .RESET_N(RESET_N), .HSYNC(HSYNC), .VSYNC(VSYNC),
      .PAD_EN_N(PAD_EN_N), .MODE(MODE), .PADDLE_POS(PADDLE_POS),
      .MOUSE_STB(MOUSE_STB), .MOUSE_DX(MOUSE_DX), .JOY_L(JOY_L), .JOY_R(JOY_R),
      .PLAYER2(PLAYER2), .COCKTAIL(COCKTAIL), .PAD_OUT(PAD_OUT), .POS(POS)
   );

   function automatic int clampi(input int v);
      return (v < 16) ? 16 : ((v > 208) ? 208 : v);
   endfunction

   function automatic int sati(input int v);
      return (v < -256) ? -256 : ((v > 255) ? 255 : v);
   endfunction

   function automatic int eff(input int p, input logic p2, input logic ck);
`ifdef PADDLE_COCKTAIL_MIRROR_EN
      return (p2 && ck) ? (16 + 208 - p) : p;
`else
      return (p2 && ck) ? p : p;
`endif
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge CLK_SRC);
   endtask

   task automatic vsync_pulse;
      int j;
      j = 0;
      if (JOY_R && !JOY_L) j = 4;
      else if (JOY_L && !JOY_R) j = -4;
      if (MODE) m_pos = clampi(int'(PADDLE_POS));
      else m_pos = clampi(m_pos + m_acc + j);
      m_acc = 0;
      VSYNC = 1'b1; tick(4);
      VSYNC = 1'b0; tick(4);
   endtask

   task automatic mouse_pkt(input int dx);
      m_acc = sati(m_acc + dx);
      MOUSE_DX  = dx[8:0];
      MOUSE_STB = ~MOUSE_STB;
      tick(4);
   endtask

   task automatic hs_pulse;
      HSYNC = 1'b1; tick(3);
      HSYNC = 1'b0; tick(3);
   endtask

   // Trigger a pulse and count HSYNC edges while PAD_OUT stays high; optional disturbance at edge 'inj'
   task automatic measure(input int inj, output int n);
      PAD_EN_N = 1'b0;
      tick(4);
      n = 0;
      while (PAD_OUT === 1'b1 && n < 400) begin
         hs_pulse();
         n++;
         if (n == inj) begin
            PAD_EN_N = 1'b1; tick(3);
            PAD_EN_N = 1'b0; tick(3);
            MODE = 1'b1; PADDLE_POS = 8'd16;
            vsync_pulse();
         end
      end
      PAD_EN_N = 1'b1;
      tick(4);
   endtask

   task automatic test_reset;
      RESET_N = 1'b0;
      tick(3);
      n_checks++;
      if (PAD_OUT !== 1'b0) $display("FAIL reset_pad: got %0d expected 0", PAD_OUT); else n_pass++;
      n_checks++;
      if (POS !== 8'd112) $display("FAIL reset_pos: got %0d expected 112", POS); else n_pass++;
      RESET_N = 1'b1;
      m_pos = 112; m_acc = 0;
      tick(3);
   endtask

   task automatic test_basic;
      int n;
      MODE = 1'b0;
      vsync_pulse();
      n_checks++;
      if (POS !== 8'(m_pos)) $display("FAIL basic_pos: got %0d expected %0d", POS, m_pos); else n_pass++;
      measure(-1, n);
      n_checks++;
      if (n != 120) $display("FAIL basic_pulse: got %0d expected 120", n); else n_pass++;
   endtask

   task automatic test_absolute;
      int n;
      MODE = 1'b1; PADDLE_POS = 8'd250;
      vsync_pulse();
      n_checks++;
      if (POS !== 8'd208) $display("FAIL abs_high_pos: got %0d expected 208", POS); else n_pass++;
      measure(-1, n);
      n_checks++;
      if (n != 216) $display("FAIL abs_high_pulse: got %0d expected 216", n); else n_pass++;
      PADDLE_POS = 8'd0;
      vsync_pulse();
      n_checks++;
      if (POS !== 8'd16) $display("FAIL abs_low_pos: got %0d expected 16", POS); else n_pass++;
      measure(-1, n);
      n_checks++;
      if (n != 24) $display("FAIL abs_low_pulse: got %0d expected 24", n); else n_pass++;
   endtask

   task automatic test_mouse;
      MODE = 1'b1; PADDLE_POS = 8'd112;
      vsync_pulse();
      MODE = 1'b0;
      mouse_pkt(200);
      mouse_pkt(200);
      mouse_pkt(-50);
      vsync_pulse();
      n_checks++;
      if (POS !== 8'd208 || m_pos != 208) $display("FAIL mouse_sat_pos: got %0d expected 208", POS); else n_pass++;
      mouse_pkt(-150);
      vsync_pulse();
      n_checks++;
      if (POS !== 8'd58) $display("FAIL mouse_neg_pos: got %0d expected 58", POS); else n_pass++;
   endtask

   task automatic test_joystick;
      MODE = 1'b1; PADDLE_POS = 8'd112;
      vsync_pulse();
      MODE = 1'b0; JOY_R = 1'b1;
      repeat (5) vsync_pulse();
      n_checks++;
      if (POS !== 8'd132) $display("FAIL joy_right_pos: got %0d expected 132", POS); else n_pass++;
      JOY_L = 1'b1;
      repeat (3) vsync_pulse();
      n_checks++;
      if (POS !== 8'd132) $display("FAIL joy_both_pos: got %0d expected 132", POS); else n_pass++;
      JOY_R = 1'b0;
      repeat (2) vsync_pulse();
      n_checks++;
      if (POS !== 8'd124) $display("FAIL joy_left_pos: got %0d expected 124", POS); else n_pass++;
      JOY_L = 1'b0;
   endtask

   task automatic test_simultaneous;
      MODE = 1'b1; PADDLE_POS = 8'd100;
      vsync_pulse();
      MODE = 1'b0;
      mouse_pkt(30);
      // frame consumes the old accumulator, the coincident packet seeds the new one
      m_pos = clampi(m_pos + m_acc);
      m_acc = -20;
      MOUSE_DX = 9'h1EC;
      MOUSE_STB = ~MOUSE_STB;
      VSYNC = 1'b1; tick(4);
      VSYNC = 1'b0; tick(4);
      n_checks++;
      if (POS !== 8'(m_pos)) $display("FAIL simul_frame_pos: got %0d expected %0d", POS, m_pos); else n_pass++;
      vsync_pulse();
      n_checks++;
      if (POS !== 8'd110) $display("FAIL simul_next_pos: got %0d expected 110", POS); else n_pass++;
   endtask

   task automatic test_mid_pulse;
      int n, exp_len;
      MODE = 1'b1; PADDLE_POS = 8'd150;
      vsync_pulse();
      exp_len = 8 + eff(m_pos, PLAYER2, COCKTAIL);
      measure(20, n);
      n_checks++;
      if (n != exp_len) $display("FAIL mid_pulse_len: got %0d expected %0d", n, exp_len); else n_pass++;
      n_checks++;
      if (POS !== 8'd16) $display("FAIL mid_pulse_pos: got %0d expected 16", POS); else n_pass++;
   endtask

   task automatic test_reset_mid_pulse;
      int n;
      MODE = 1'b1; PADDLE_POS = 8'd60;
      vsync_pulse();
      PAD_EN_N = 1'b0;
      tick(4);
      repeat (10) hs_pulse();
      n_checks++;
      if (PAD_OUT !== 1'b1) $display("FAIL pre_reset_pad: got %0d expected 1", PAD_OUT); else n_pass++;
      RESET_N = 1'b0;
      PAD_EN_N = 1'b1;
      tick(1);
      n_checks++;
      if (PAD_OUT !== 1'b0) $display("FAIL reset_mid_pad: got %0d expected 0", PAD_OUT); else n_pass++;
      n_checks++;
      if (POS !== 8'd112) $display("FAIL reset_mid_pos: got %0d expected 112", POS); else n_pass++;
      tick(1);
      RESET_N = 1'b1;
      m_pos = 112; m_acc = 0;
      tick(3);
      measure(-1, n);
      n_checks++;
      if (n != 120) $display("FAIL reset_mid_retrigger: got %0d expected 120", n); else n_pass++;
   endtask

   task automatic test_mirror;
      int n, e;
      MODE = 1'b1; PADDLE_POS = 8'd50; PLAYER2 = 1'b1; COCKTAIL = 1'b1;
      vsync_pulse();
      e = eff(m_pos, PLAYER2, COCKTAIL);
      n_checks++;
      if (POS !== 8'(e)) $display("FAIL mirror_pos: got %0d expected %0d", POS, e); else n_pass++;
      measure(-1, n);
      n_checks++;
      if (n != 8 + e) $display("FAIL mirror_pulse: got %0d expected %0d", n, 8 + e); else n_pass++;
      PLAYER2 = 1'b0;
      tick(3);
      n_checks++;
      if (POS !== 8'd50) $display("FAIL mirror_off_pos: got %0d expected 50", POS); else n_pass++;
      COCKTAIL = 1'b0;
   endtask

   task automatic test_random;
      int n, k, e;
      for (int it = 0; it < 30; it++) begin
         MODE       = 1'($urandom_range(0, 1));
         PADDLE_POS = 8'($urandom_range(0, 255));
         JOY_L      = 1'($urandom_range(0, 1));
         JOY_R      = 1'($urandom_range(0, 1));
         PLAYER2    = 1'($urandom_range(0, 1));
         COCKTAIL   = 1'($urandom_range(0, 1));
         k = $urandom_range(0, 3);
         for (int p = 0; p < k; p++) mouse_pkt(int'($urandom_range(0, 511)) - 256);
         vsync_pulse();
         e = eff(m_pos, PLAYER2, COCKTAIL);
         n_checks++;
         if (POS !== 8'(e)) $display("FAIL rand_pos[%0d]: got %0d expected %0d", it, POS, e); else n_pass++;
         if (it % 6 == 5) begin
            measure(-1, n);
            n_checks++;
            if (n != 8 + e) $display("FAIL rand_pulse[%0d]: got %0d expected %0d", it, n, 8 + e); else n_pass++;
         end
      end
      JOY_L = 1'b0; JOY_R = 1'b0; PLAYER2 = 1'b0; COCKTAIL = 1'b0;
   endtask

   initial begin
      tick(1);
      test_reset();
      test_basic();
      test_absolute();
      test_mouse();
      test_joystick();
      test_simultaneous();
      test_mid_pulse();
      test_reset_mid_pulse();
      test_mirror();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
